// File: rtl/fetch_controller.sv
// fetch_controller: generates the sequential PC stream, issues in-order
// instruction reads under a credit limit, buffers returning words in a small
// FIFO and hands them to the instruction queue. A redirect empties the FIFO,
// marks every in-flight read for discard and restarts fetch at the new PC.
module fetch_controller #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        halt_in,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  output logic        mem_req_valid_out,
  output logic [31:0] mem_req_addr_out,
  input  logic        mem_req_ready_in,
  input  logic        mem_resp_valid_in,
  input  logic [31:0] mem_resp_data_in,
  output logic        iq_valid_out,
  output logic [31:0] iq_instruction_out,
  input  logic        iq_ready_in,
  output logic [31:0] pc_out
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW:0]   MAX_CREDIT = (CW + 1)'(MAX_OUTSTANDING);
  localparam logic [AW-1:0] LAST_IDX   = AW'(MAX_OUTSTANDING - 1);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] drop_count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   buf_mem [MAX_OUTSTANDING];

  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          resp_dec;
  logic          push;
  logic          pop;
  logic [CW-1:0] outstanding_nxt;

  // FIFO pointers wrap at the buffer depth, which need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + AW'(1);
  endfunction

  // Credits cover both in-flight reads and buffered words, so a returning
  // word always has a free buffer slot. Reset gates the request so it drops
  // immediately on assertion rather than at the next edge.
  assign credit_used       = {1'b0, outstanding} + {1'b0, buf_count};
  assign mem_req_valid_out = rst_in && !halt_in && !redirect_valid_in &&
                             (credit_used < MAX_CREDIT);
  assign mem_req_addr_out  = pc;
  assign pc_out            = pc;
  assign req_fire          = mem_req_valid_out && mem_req_ready_in;

  // A response in a redirect cycle or while stale reads remain is dropped.
  assign resp_dec = mem_resp_valid_in && (outstanding != '0);
  assign push     = mem_resp_valid_in && !redirect_valid_in && (drop_count == '0);

  // The queue never sees a word during a redirect; the buffer is being flushed.
  assign iq_valid_out       = (buf_count != '0) && !redirect_valid_in;
  assign iq_instruction_out = (buf_count != '0) ? buf_mem[rd_ptr] : '0;
  assign pop                = iq_valid_out && iq_ready_in;

  // In-flight count after this cycle's acceptance and response.
  always_comb begin
    outstanding_nxt = outstanding;
    unique case ({req_fire, resp_dec})
      2'b10:   outstanding_nxt = outstanding + CW'(1);
      2'b01:   outstanding_nxt = outstanding - CW'(1);
      default: outstanding_nxt = outstanding;
    endcase
  end

  // Control state: PC, credit counters, discard count and FIFO pointers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
      buf_count   <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid_in) begin
        pc         <= redirect_pc_in;
        drop_count <= outstanding_nxt;
        buf_count  <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
      end else begin
        if (req_fire)
          pc <= pc + 32'd4;
        if (mem_resp_valid_in && (drop_count != '0))
          drop_count <= drop_count - CW'(1);
        if (push)
          wr_ptr <= ptr_inc(wr_ptr);
        if (pop)
          rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)
          buf_count <= buf_count + CW'(1);
        else if (pop && !push)
          buf_count <= buf_count - CW'(1);
      end
    end
  end

  // Buffer storage carries data only; validity comes from buf_count.
  always_ff @(posedge clk_in) begin
    if (push)
      buf_mem[wr_ptr] <= mem_resp_data_in;
  end

  // A response with nothing in flight means the memory broke ordering.
  a_resp_has_request: assert property (
    @(posedge clk_in) disable iff (!rst_in)
    mem_resp_valid_in |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a small in-order memory model with a
// programmable latency, a queue sink with controllable ready, and one task
// per scenario with hand-derived expected values.
module tb_fetch_controller;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        halt_in = 1'b0;
  logic        redirect_valid_in = 1'b0;
  logic [31:0] redirect_pc_in = '0;
  logic        mem_req_valid_out;
  logic [31:0] mem_req_addr_out;
  logic        mem_req_ready_in = 1'b1;
  logic        mem_resp_valid_in = 1'b0;
  logic [31:0] mem_resp_data_in = '0;
  logic        iq_valid_out;
  logic [31:0] iq_instruction_out;
  logic        iq_ready_in = 1'b1;
  logic [31:0] pc_out;

  int tests_run = 0;
  int tests_failed = 0;

  int          lat = 1;
  int          cyc = 0;
  logic [31:0] pend_addr[$];
  int          pend_rdy[$];
  logic [31:0] got[$];
  logic [31:0] reqs[$];

  fetch_controller #(.RESET_PC(32'h0000_0000), .MAX_OUTSTANDING(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .halt_in(halt_in),
    .redirect_valid_in(redirect_valid_in), .redirect_pc_in(redirect_pc_in),
    .mem_req_valid_out(mem_req_valid_out), .mem_req_addr_out(mem_req_addr_out),
    .mem_req_ready_in(mem_req_ready_in), .mem_resp_valid_in(mem_resp_valid_in),
    .mem_resp_data_in(mem_resp_data_in), .iq_valid_out(iq_valid_out),
    .iq_instruction_out(iq_instruction_out), .iq_ready_in(iq_ready_in),
    .pc_out(pc_out));

  always #5 clk_in = ~clk_in;

  // Memory returns the bitwise inverse of the address as the instruction word.
  task automatic clear_model();
    pend_addr.delete();
    pend_rdy.delete();
    mem_resp_valid_in = 1'b0;
    mem_resp_data_in  = '0;
  endtask

  // One clock: observe handshakes, cross the edge, advance the memory model.
  task automatic cycle();
    logic        fire;
    logic        taken;
    logic [31:0] faddr;
    #1;
    fire  = mem_req_valid_out && mem_req_ready_in;
    faddr = mem_req_addr_out;
    taken = mem_resp_valid_in;
    if (iq_valid_out && iq_ready_in) got.push_back(iq_instruction_out);
    @(posedge clk_in);
    #1;
    cyc++;
    if (taken) begin
      void'(pend_addr.pop_front());
      void'(pend_rdy.pop_front());
    end
    if (fire) begin
      pend_addr.push_back(faddr);
      pend_rdy.push_back(cyc - 1 + lat);
      reqs.push_back(faddr);
    end
    if (pend_addr.size() > 0 && pend_rdy[0] <= cyc) begin
      mem_resp_valid_in = 1'b1;
      mem_resp_data_in  = ~pend_addr[0];
    end else begin
      mem_resp_valid_in = 1'b0;
      mem_resp_data_in  = '0;
    end
  endtask

  task automatic apply_reset();
    rst_in = 1'b0;
    halt_in = 1'b0;
    redirect_valid_in = 1'b0;
    redirect_pc_in = '0;
    iq_ready_in = 1'b1;
    clear_model();
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    got.delete();
    reqs.delete();
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    #3;
    tests_run++; if (mem_req_valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b, expected 0", mem_req_valid_out); end
    tests_run++; if (iq_valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_iq_valid: got %b, expected 0", iq_valid_out); end
    tests_run++; if (iq_instruction_out !== 32'h0) begin tests_failed++; $display("FAIL reset_iq_instr: got %h, expected 00000000", iq_instruction_out); end
    tests_run++; if (pc_out !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h, expected 00000000", pc_out); end
  endtask

  task automatic test_stream();
    apply_reset();
    lat = 1;
    cycle(); cycle();
    tests_run++; if (mem_req_valid_out !== 1'b0) begin tests_failed++; $display("FAIL stream_credit_stall: got %b, expected 0", mem_req_valid_out); end
    repeat (10) cycle();
    for (int i = 0; i < 6; i++) begin
      tests_run++; if (reqs[i] !== 32'(4 * i)) begin tests_failed++; $display("FAIL stream_req%0d: got %h, expected %h", i, reqs[i], 32'(4 * i)); end
      tests_run++; if (got[i] !== ~32'(4 * i)) begin tests_failed++; $display("FAIL stream_word%0d: got %h, expected %h", i, got[i], ~32'(4 * i)); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    lat = 1;
    iq_ready_in = 1'b0;
    repeat (6) cycle();
    tests_run++; if (mem_req_valid_out !== 1'b0) begin tests_failed++; $display("FAIL bp_req_blocked: got %b, expected 0", mem_req_valid_out); end
    tests_run++; if (iq_valid_out !== 1'b1) begin tests_failed++; $display("FAIL bp_iq_valid: got %b, expected 1", iq_valid_out); end
    tests_run++; if (iq_instruction_out !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL bp_iq_head: got %h, expected ffffffff", iq_instruction_out); end
    tests_run++; if (reqs.size() !== 2) begin tests_failed++; $display("FAIL bp_req_count: got %0d, expected 2", reqs.size()); end
    iq_ready_in = 1'b1;
    repeat (4) cycle();
    tests_run++; if (got[0] !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL bp_drain0: got %h, expected ffffffff", got[0]); end
    tests_run++; if (got[1] !== 32'hFFFF_FFFB) begin tests_failed++; $display("FAIL bp_drain1: got %h, expected fffffffb", got[1]); end
    tests_run++; if (reqs[2] !== 32'h8) begin tests_failed++; $display("FAIL bp_resume: got %h, expected 00000008", reqs[2]); end
  endtask

  task automatic test_redirect_flush();
    apply_reset();
    lat = 3;
    cycle(); cycle();
    redirect_valid_in = 1'b1;
    redirect_pc_in = 32'h100;
    cycle();
    redirect_valid_in = 1'b0;
    #1;
    tests_run++; if (pc_out !== 32'h100) begin tests_failed++; $display("FAIL flush_pc: got %h, expected 00000100", pc_out); end
    tests_run++; if (mem_req_valid_out !== 1'b0) begin tests_failed++; $display("FAIL flush_no_credit: got %b, expected 0", mem_req_valid_out); end
    repeat (9) cycle();
    tests_run++; if (reqs[2] !== 32'h100) begin tests_failed++; $display("FAIL flush_restart_req: got %h, expected 00000100", reqs[2]); end
    tests_run++; if (got[0] !== ~32'h100) begin tests_failed++; $display("FAIL flush_first_word: got %h, expected %h", got[0], ~32'h100); end
    tests_run++; if (got[1] !== ~32'h104) begin tests_failed++; $display("FAIL flush_second_word: got %h, expected %h", got[1], ~32'h104); end
  endtask

  task automatic test_redirect_with_response();
    apply_reset();
    lat = 1;
    iq_ready_in = 1'b0;
    cycle(); cycle();
    redirect_valid_in = 1'b1;
    redirect_pc_in = 32'h200;
    #1;
    tests_run++; if (iq_valid_out !== 1'b0) begin tests_failed++; $display("FAIL redir_iq_forced: got %b, expected 0", iq_valid_out); end
    tests_run++; if (mem_resp_valid_in !== 1'b1) begin tests_failed++; $display("FAIL redir_resp_present: got %b, expected 1", mem_resp_valid_in); end
    cycle();
    redirect_valid_in = 1'b0;
    #1;
    tests_run++; if (iq_valid_out !== 1'b0) begin tests_failed++; $display("FAIL redir_buf_empty: got %b, expected 0", iq_valid_out); end
    tests_run++; if (iq_instruction_out !== 32'h0) begin tests_failed++; $display("FAIL redir_instr_zero: got %h, expected 00000000", iq_instruction_out); end
    tests_run++; if (mem_req_addr_out !== 32'h200 || mem_req_valid_out !== 1'b1) begin tests_failed++; $display("FAIL redir_restart: got %b/%h, expected 1/00000200", mem_req_valid_out, mem_req_addr_out); end
    iq_ready_in = 1'b1;
    repeat (4) cycle();
    tests_run++; if (got[0] !== ~32'h200) begin tests_failed++; $display("FAIL redir_first_word: got %h, expected %h", got[0], ~32'h200); end
    tests_run++; if (got[1] !== ~32'h204) begin tests_failed++; $display("FAIL redir_second_word: got %h, expected %h", got[1], ~32'h204); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    lat = 1;
    iq_ready_in = 1'b0;
    repeat (3) cycle();
    redirect_valid_in = 1'b1;
    redirect_pc_in = 32'h300;
    cycle();
    redirect_pc_in = 32'h400;
    cycle();
    redirect_valid_in = 1'b0;
    #1;
    tests_run++; if (pc_out !== 32'h400) begin tests_failed++; $display("FAIL b2b_pc: got %h, expected 00000400", pc_out); end
    tests_run++; if (iq_valid_out !== 1'b0) begin tests_failed++; $display("FAIL b2b_full_buf_flushed: got %b, expected 0", iq_valid_out); end
    iq_ready_in = 1'b1;
    repeat (3) cycle();
    tests_run++; if (reqs[2] !== 32'h400) begin tests_failed++; $display("FAIL b2b_req: got %h, expected 00000400", reqs[2]); end
    tests_run++; if (got[0] !== ~32'h400) begin tests_failed++; $display("FAIL b2b_word: got %h, expected %h", got[0], ~32'h400); end
  endtask

  task automatic test_pc_wrap();
    apply_reset();
    lat = 1;
    redirect_valid_in = 1'b1;
    redirect_pc_in = 32'hFFFF_FFFC;
    cycle();
    redirect_valid_in = 1'b0;
    repeat (4) cycle();
    tests_run++; if (reqs[0] !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_req0: got %h, expected fffffffc", reqs[0]); end
    tests_run++; if (reqs[1] !== 32'h0) begin tests_failed++; $display("FAIL wrap_req1: got %h, expected 00000000", reqs[1]); end
    tests_run++; if (got[0] !== 32'h0000_0003) begin tests_failed++; $display("FAIL wrap_word0: got %h, expected 00000003", got[0]); end
    tests_run++; if (got[1] !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL wrap_word1: got %h, expected ffffffff", got[1]); end
  endtask

  task automatic test_halt();
    apply_reset();
    lat = 3;
    cycle();
    halt_in = 1'b1;
    #1;
    tests_run++; if (mem_req_valid_out !== 1'b0) begin tests_failed++; $display("FAIL halt_blocks: got %b, expected 0", mem_req_valid_out); end
    repeat (5) cycle();
    tests_run++; if (reqs.size() !== 1) begin tests_failed++; $display("FAIL halt_req_count: got %0d, expected 1", reqs.size()); end
    tests_run++; if (got[0] !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL halt_drain: got %h, expected ffffffff", got[0]); end
    halt_in = 1'b0;
    #1;
    tests_run++; if (mem_req_valid_out !== 1'b1 || mem_req_addr_out !== 32'h4) begin tests_failed++; $display("FAIL halt_resume: got %b/%h, expected 1/00000004", mem_req_valid_out, mem_req_addr_out); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    lat = 1;
    repeat (3) cycle();
    tests_run++; if (mem_req_valid_out !== 1'b1 || iq_valid_out !== 1'b1 || iq_instruction_out !== ~32'h4 || pc_out !== 32'h8) begin
      tests_failed++; $display("FAIL arst_pre_state: got %b/%b/%h/%h, expected 1/1/%h/00000008", mem_req_valid_out, iq_valid_out, iq_instruction_out, pc_out, ~32'h4);
    end
    #2;
    rst_in = 1'b0;
    clear_model();
    #1;
    tests_run++; if (mem_req_valid_out !== 1'b0) begin tests_failed++; $display("FAIL arst_req_valid: got %b, expected 0", mem_req_valid_out); end
    tests_run++; if (iq_valid_out !== 1'b0) begin tests_failed++; $display("FAIL arst_iq_valid: got %b, expected 0", iq_valid_out); end
    tests_run++; if (iq_instruction_out !== 32'h0) begin tests_failed++; $display("FAIL arst_iq_instr: got %h, expected 00000000", iq_instruction_out); end
    tests_run++; if (pc_out !== 32'h0) begin tests_failed++; $display("FAIL arst_pc: got %h, expected 00000000", pc_out); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_with_response();
    test_back_to_back();
    test_pc_wrap();
    test_halt();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
